// File: rtl/dlx_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : dlx_pipe_if
// Purpose  : DLX instruction fetch stage. Owns the PC and fetches from
//            instruction memory over a req/ready handshake. Loads the IF/ID
//            register (if_id_npc, if_id_ir) for the ID stage. Takes
//            redirect, squash and halt controls from ID.
// Ports    : clk, rst (sync, active-high)
//            stall, dc_wait           - hold controls
//            id_cond, id_npc          - taken jump/branch and its target
//            id_halt, id_illegal_instr- stop fetching
//            imem_req/addr/rdata/ready- instruction memory handshake
//            if_id_npc, if_id_ir      - IF/ID register
//            if_halted                - fetch stopped
// Config   : DLX_IF_PREFETCH_BUF_EN - one-entry prefetch buffer that keeps a
//            word returned during stall/dc_wait instead of refetching it.
// Revision : 1.0 - initial release
// ============================================================================
module dlx_pipe_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_IR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        dc_wait,
    input  logic        id_cond,
    input  logic [31:0] id_npc,
    input  logic        id_halt,
    input  logic        id_illegal_instr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] if_id_npc,
    output logic [31:0] if_id_ir,
    output logic        if_halted
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HALT  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] pc_plus4;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_ir_q, buf_ir_d;

    // Wraps modulo 2^32; id_npc alignment is intentionally not checked.
    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= NOP_IR;
            npc_q       <= RESET_PC;
            buf_valid_q <= 1'b0;
            buf_ir_q    <= NOP_IR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            npc_q       <= npc_d;
            buf_valid_q <= buf_valid_d;
            buf_ir_q    <= buf_ir_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        npc_d       = npc_q;
        buf_valid_d = buf_valid_q;
        buf_ir_d    = buf_ir_q;
        imem_req    = 1'b0;
        if_halted   = 1'b0;

        case (state_q)
            S_FETCH: begin
`ifdef DLX_IF_PREFETCH_BUF_EN
                // A buffered word already covers the current pc.
                imem_req = ~buf_valid_q;
`else
                imem_req = 1'b1;
`endif
                if (dc_wait || stall) begin
                    // Hold everything. ID operands may be stale while
                    // stalled, so redirect/halt are not honoured here.
`ifdef DLX_IF_PREFETCH_BUF_EN
                    if (imem_ready && !buf_valid_q) begin
                        buf_ir_d    = imem_rdata;
                        buf_valid_d = 1'b1;
                    end
`endif
                end else if (id_halt || id_illegal_instr) begin
                    state_d     = S_HALT;
                    ir_d        = NOP_IR;
                    buf_valid_d = 1'b0;
                end else if (id_cond) begin
                    // Squash the wrong-path fetch: one-bubble penalty.
                    pc_d        = id_npc;
                    ir_d        = NOP_IR;
                    buf_valid_d = 1'b0;
`ifdef DLX_IF_PREFETCH_BUF_EN
                end else if (buf_valid_q) begin
                    ir_d        = buf_ir_q;
                    npc_d       = pc_plus4;
                    pc_d        = pc_plus4;
                    buf_valid_d = 1'b0;
`endif
                end else if (imem_ready) begin
                    ir_d  = imem_rdata;
                    npc_d = pc_plus4;
                    pc_d  = pc_plus4;
                end else begin
                    ir_d = NOP_IR;
                end
            end
            S_HALT: begin
                if_halted = 1'b1;
                ir_d      = NOP_IR;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign if_id_npc = npc_q;
    assign if_id_ir  = ir_q;

endmodule
`default_nettype wire
